// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide controller.
package md_pkg;

   // md op encodings as presented by EX on E_md_op
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_div_iter.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
// The dividend rides in the low end of quo and is consumed MSB first.
module md_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // rem < dvsr always holds, so shifted fits WIDTH+1 bits and the
   // restored (non-fitting) case fits back into WIDTH bits.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvsr});
      diff    = shifted - {1'b0, dvsr};
      rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_nx  = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO owner. Multiply is a fixed-latency
// product captured up front; divide iterates md_div_iter WIDTH times and
// spends one extra cycle on sign correction and commit.
module md_hilo_ctrl
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             E_md_start,
   input  logic [1:0]       E_md_op,
   input  logic [WIDTH-1:0] E_srcA,
   input  logic [WIDTH-1:0] E_srcB,
   input  logic             E_mthi,
   input  logic             E_mtlo,
   input  logic             ID_md_use,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             md_stall
);

   localparam int CW = $clog2(WIDTH + 2);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, a_raw_q;
   logic             neg_q_q, neg_r_q;
   logic             done_q;

   logic             is_signed;
   logic [2*WIDTH-1:0] ext_a, ext_b, mul_prod;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic             mul_last, div_last, div_zero;

   md_div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .rem    (rem_q),
      .quo    (quo_q),
      .dvsr   (dvsr_q),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   // Operand prep: sign/zero extension for the product, magnitudes for divide
   always_comb begin
      is_signed = (E_md_op == MD_MULT) || (E_md_op == MD_DIV);
      ext_a     = is_signed ? {{WIDTH{E_srcA[WIDTH-1]}}, E_srcA} : {{WIDTH{1'b0}}, E_srcA};
      ext_b     = is_signed ? {{WIDTH{E_srcB[WIDTH-1]}}, E_srcB} : {{WIDTH{1'b0}}, E_srcB};
      mul_prod  = ext_a * ext_b;
      a_abs     = (is_signed && E_srcA[WIDTH-1]) ? (~E_srcA + 1'b1) : E_srcA;
      b_abs     = (is_signed && E_srcB[WIDTH-1]) ? (~E_srcB + 1'b1) : E_srcB;
      mul_last  = (cnt_q == CW'(MUL_CYCLES - 1));
      div_last  = (cnt_q == CW'(WIDTH));
      div_zero  = (dvsr_q == '0);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (E_md_start) state_d = E_md_op[1] ? ST_DIV : ST_MUL;
         ST_MUL:  if (mul_last)   state_d = ST_IDLE;
         ST_DIV:  if (div_last)   state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, HI/LO commit and mthi/mtlo
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         a_raw_q <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (E_md_start) begin
                  cnt_q <= '0;
                  if (!E_md_op[1]) begin
                     prod_q <= mul_prod;
                  end else begin
                     rem_q   <= '0;
                     quo_q   <= a_abs;
                     dvsr_q  <= b_abs;
                     a_raw_q <= E_srcA;
                     neg_q_q <= is_signed & (E_srcA[WIDTH-1] ^ E_srcB[WIDTH-1]);
                     neg_r_q <= is_signed & E_srcA[WIDTH-1];
                  end
               end else begin
                  if (E_mthi) hi <= E_srcA;
                  if (E_mtlo) lo <= E_srcA;
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  hi     <= prod_q[2*WIDTH-1:WIDTH];
                  lo     <= prod_q[WIDTH-1:0];
                  done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DIV: begin
               if (div_last) begin
                  // divide-by-zero returns the raw dividend and all-ones, unsigned
                  if (div_zero) begin
                     hi <= a_raw_q;
                     lo <= '1;
                  end else begin
                     hi <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
                     lo <= neg_q_q ? (~quo_q + 1'b1) : quo_q;
                  end
                  done_q <= 1'b1;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status and hazard outputs
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = done_q;
      md_stall = ID_md_use & (busy | E_md_start);
   end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: multiply/divide results, latency, stall,
// done pulse, mthi/mtlo priority and asynchronous reset mid-divide.
module tb_md_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        E_md_start, E_mthi, E_mtlo, ID_md_use;
   logic [1:0]  E_md_op;
   logic [31:0] E_srcA, E_srcB;
   logic [31:0] hi, lo;
   logic        busy, done, md_stall;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] cur_hi, cur_lo;

   md_hilo_ctrl #(.WIDTH(32), .MUL_CYCLES(5)) dut (
      .clk(clk), .rst(rst),
      .E_md_start(E_md_start), .E_md_op(E_md_op),
      .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_mthi(E_mthi), .E_mtlo(E_mtlo), .ID_md_use(ID_md_use),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   // single comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one md op with mfhi-style ID use, track busy length and results.
   // mthi is asserted alongside start (start must win) and again mid-op
   // (must be ignored while busy).
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int lat);
      int  n;
      logic stall_ok;
      @(negedge clk);
      E_md_start = 1'b1; E_md_op = op; E_srcA = a; E_srcB = b;
      E_mthi = 1'b1; ID_md_use = 1'b1;
      #1 check({tag, " stall_at_start"}, {31'd0, md_stall}, 32'd1);
      @(negedge clk);
      E_md_start = 1'b0; E_mthi = 1'b0;
      n = 0; stall_ok = 1'b1;
      while (busy && n < 200) begin
         if (!md_stall) stall_ok = 1'b0;
         if (n == 0) check({tag, " hi_kept_start_wins"}, hi, cur_hi);
         if (n == 2) begin E_mthi = 1'b1; E_srcA = 32'hDEAD_0001; end
         if (n == 3) begin
            E_mthi = 1'b0;
            check({tag, " hi_kept_mthi_busy"}, hi, cur_hi);
         end
         n++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, n, lat);
      check({tag, " stall_while_busy"}, {31'd0, stall_ok}, 32'd1);
      check({tag, " stall_released"}, {31'd0, md_stall}, 32'd0);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      check({tag, " done_pulse"}, {31'd0, done}, 32'd1);
      cur_hi = eh; cur_lo = el;
      ID_md_use = 1'b0;
      @(negedge clk);
      check({tag, " done_clears"}, {31'd0, done}, 32'd0);
      check({tag, " hi_hold"}, hi, eh);
   endtask

   initial begin
      rst = 1'b1; E_md_start = 1'b0; E_md_op = 2'b00; E_srcA = '0; E_srcB = '0;
      E_mthi = 1'b0; E_mtlo = 1'b0; ID_md_use = 1'b0;
      cur_hi = '0; cur_lo = '0;
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("mult",   2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      run_op("multu",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
      run_op("div",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("divu",   2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 33);
      run_op("div_nb", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
      run_op("div0",   2'b10, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 33);

      // reset in the middle of a divu discards it
      @(negedge clk);
      E_md_start = 1'b1; E_md_op = 2'b11; E_srcA = 32'd100; E_srcB = 32'd7;
      @(negedge clk);
      E_md_start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst hi", hi, 32'd0);
      check("midrst lo", lo, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst hi", hi, 32'd0);
      check("post_rst done", {31'd0, done}, 32'd0);

      // mthi / mtlo in IDLE
      E_mthi = 1'b1; E_srcA = 32'h0000_CAFE;
      @(negedge clk);
      E_mthi = 1'b0;
      check("mthi hi", hi, 32'h0000_CAFE);
      check("mthi lo", lo, 32'd0);
      E_mtlo = 1'b1; E_srcA = 32'h0000_BEEF;
      @(negedge clk);
      E_mtlo = 1'b0;
      check("mtlo lo", lo, 32'h0000_BEEF);
      check("mtlo hi", hi, 32'h0000_CAFE);
      cur_hi = 32'h0000_CAFE; cur_lo = 32'h0000_BEEF;

      // controller is usable again after reset
      run_op("divu2", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
